// File: rtl/seg7_display_scanner_if.sv
// Display-side bus between the calculator top and the seven-segment scanner.
// master drives the number to show; slave is the scanner producing the pins.
interface seg7_display_scanner_if;
  logic [15:0] value;
  logic        dec_mode;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic        conv_busy;

  modport master (output value, dec_mode, input anodes, segments, dp, conv_busy);
  modport slave  (input value, dec_mode, output anodes, segments, dp, conv_busy);
endinterface

// File: rtl/seg7_display_scanner.sv
// Latches a 16-bit value, renders it as hex or decimal (sequential double-dabble)
// and scans digit positions 0..5. Optional SEG7_SIGNED_DISPLAY_EN shows signed decimal.
module seg7_display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_display_scanner_if.slave   bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [4:0] D_BLANK = 5'd16;
  localparam logic [4:0] D_MINUS = 5'd17;

  typedef enum logic [1:0] {IDLE, HEXLOAD, CONV, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     last_value_q, last_value_d;
  logic            last_mode_q, last_mode_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [15:0]     sh_q, sh_d;
  logic [3:0]      iter_q, iter_d;
  logic [5:0][4:0] dbuf_q, dbuf_d;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      anodes_q;
  logic [6:0]      seg_q;
  logic [4:0]      sign_digit;

  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [4:0] d);
    case (d)
      5'd0:  return 7'b1000000;
      5'd1:  return 7'b1111001;
      5'd2:  return 7'b0100100;
      5'd3:  return 7'b0110000;
      5'd4:  return 7'b0011001;
      5'd5:  return 7'b0010010;
      5'd6:  return 7'b0000010;
      5'd7:  return 7'b1111000;
      5'd8:  return 7'b0000000;
      5'd9:  return 7'b0010000;
      5'd10: return 7'b0001000;
      5'd11: return 7'b0000011;
      5'd12: return 7'b1000110;
      5'd13: return 7'b0100001;
      5'd14: return 7'b0000110;
      5'd15: return 7'b0001110;
      D_MINUS: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

`ifdef SEG7_SIGNED_DISPLAY_EN
  logic        neg_q, neg_d;
  logic [15:0] mag;
  // 16 bits suffice: the only input whose negation needs bit 16 is zero, which is never negated
  assign mag        = ~bus.value + 16'd1;
  assign sign_digit = neg_q ? D_MINUS : D_BLANK;

  always_ff @(posedge clk or posedge reset)
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
`else
  assign sign_digit = D_BLANK;
`endif

  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    last_mode_d  = last_mode_q;
    bcd_d        = bcd_q;
    sh_d         = sh_q;
    iter_d       = iter_q;
    dbuf_d       = dbuf_q;
`ifdef SEG7_SIGNED_DISPLAY_EN
    neg_d        = neg_q;
`endif
    case (state_q)
      IDLE: if (bus.value != last_value_q || bus.dec_mode != last_mode_q) begin
        last_value_d = bus.value;
        last_mode_d  = bus.dec_mode;
        bcd_d        = '0;
        iter_d       = '0;
`ifdef SEG7_SIGNED_DISPLAY_EN
        neg_d        = bus.dec_mode & bus.value[15];
        sh_d         = neg_d ? mag : bus.value;
`else
        sh_d         = bus.value;
`endif
        state_d      = bus.dec_mode ? CONV : HEXLOAD;
      end
      HEXLOAD: begin
        for (int i = 0; i < 4; i++) dbuf_d[i] = {1'b0, last_value_q[4*i +: 4]};
        dbuf_d[4] = D_BLANK;
        dbuf_d[5] = D_BLANK;
        state_d   = IDLE;
      end
      CONV: begin
        {bcd_d, sh_d} = {add3(bcd_q), sh_q} << 1;
        iter_d        = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        for (int i = 0; i < 5; i++) dbuf_d[i] = {1'b0, bcd_q[4*i +: 4]};
        dbuf_d[5] = sign_digit;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      last_value_q <= '0;
      last_mode_q  <= 1'b0;
      bcd_q        <= '0;
      sh_q         <= '0;
      iter_q       <= '0;
      dbuf_q       <= {D_BLANK, 25'd0};
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      last_mode_q  <= last_mode_d;
      bcd_q        <= bcd_d;
      sh_q         <= sh_d;
      iter_q       <= iter_d;
      dbuf_q       <= dbuf_d;
    end

  // Pins are registered from the index, so they lag an index change by one clock
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      anodes_q <= 8'hFF;
      seg_q    <= 7'h7F;
    end else begin
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      anodes_q <= ~(8'd1 << idx_q);
      seg_q    <= seg7(dbuf_q[idx_q]);
    end

  assign bus.anodes    = anodes_q;
  assign bus.segments  = seg_q;
  assign bus.dp        = 1'b1;
  assign bus.conv_busy = (state_q == CONV);
endmodule
